// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel_feeder block.
package pixel_pkg;
  localparam int IMAGE_W = 128;
  localparam int IMAGE_H = 128;
  localparam int ADDR_W  = 14;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic {S_IDLE, S_ACK} state_t;
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pixels. Pointers carry one extra wrap bit so full and empty differ.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  pixel_t din,
  output logic   full,
  output logic   empty,
  output pixel_t head
);
  localparam int IW = $clog2(FIFO_DEPTH);

  pixel_t        mem [FIFO_DEPTH];
  logic [IW:0]   wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign head  = mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[IW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (IW+1)'(1);
      end
      if (pop && !empty)
        rd_ptr <= rd_ptr + (IW+1)'(1);
    end
  end
endmodule

// File: rtl/pixel_feeder.sv
// Buffers upstream pixels and answers framebuf's four-phase req/ack, one pixel per handshake.
// Optional per-frame channel checksums when PIXEL_FEEDER_CHECKSUM_EN is defined.
module pixel_feeder
  import pixel_pkg::*;
#(
  parameter int IMAGE_SIZE = 16384,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        pixel_a_in,
  input  logic [7:0]        pixel_b_in,
  input  logic [7:0]        pixel_c_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              recev_req,
  output logic              recev_ack,
  output logic [7:0]        pixel_a_out,
  output logic [7:0]        pixel_b_out,
  output logic [7:0]        pixel_c_out,
  output logic [ADDR_W-1:0] address,
  output logic              frame_done
`ifdef PIXEL_FEEDER_CHECKSUM_EN
  ,
  output logic [21:0]       sum_r,
  output logic [21:0]       sum_g,
  output logic [21:0]       sum_b
`endif
);
  state_t state, state_n;
  logic   push, pop, load, full, empty, last;
  pixel_t head, pix_q;

  assign in_ready = !full;
  assign push     = in_valid && !full;

  pixel_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ('{r: pixel_a_in, g: pixel_b_in, b: pixel_c_in}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    pop     = 1'b0;
    case (state)
      S_IDLE: if (recev_req && !empty) begin
        load    = 1'b1;
        state_n = S_ACK;
      end
      S_ACK: if (!recev_req) begin
        pop     = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign recev_ack   = (state == S_ACK);
  assign pixel_a_out = pix_q.r;
  assign pixel_b_out = pix_q.g;
  assign pixel_c_out = pix_q.b;
  assign last        = pop && (address == ADDR_W'(IMAGE_SIZE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q      <= '0;
      address    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last;
      if (load) pix_q <= head;
      if (pop)  address <= last ? '0 : address + ADDR_W'(1);
    end
  end

`ifdef PIXEL_FEEDER_CHECKSUM_EN
  logic [21:0] acc_r, acc_g, acc_b;

  // The popped pixel is the one still held in pix_q; the final pop folds into the latched sums.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= '0; acc_g <= '0; acc_b <= '0;
      sum_r <= '0; sum_g <= '0; sum_b <= '0;
    end else if (pop) begin
      if (last) begin
        sum_r <= acc_r + 22'(pix_q.r);
        sum_g <= acc_g + 22'(pix_q.g);
        sum_b <= acc_b + 22'(pix_q.b);
        acc_r <= '0; acc_g <= '0; acc_b <= '0;
      end else begin
        acc_r <= acc_r + 22'(pix_q.r);
        acc_g <= acc_g + 22'(pix_q.g);
        acc_b <= acc_b + 22'(pix_q.b);
      end
    end
  end
`endif
endmodule

// File: tb/tb_pixel_feeder.sv
// Self-checking bench for pixel_feeder: directed table, corner sequences, full frame, random vs queue model.
module tb_pixel_feeder;
  localparam int IMG   = 16384;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a_in, b_in, c_in, a_out, b_out, c_out;
  logic        in_valid, in_ready, recev_req, recev_ack, frame_done;
  logic [13:0] address;
`ifdef PIXEL_FEEDER_CHECKSUM_EN
  logic [21:0] sum_r, sum_g, sum_b;
`endif

  pixel_feeder #(.IMAGE_SIZE(IMG), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_a_in  (a_in),
    .pixel_b_in  (b_in),
    .pixel_c_in  (c_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .recev_req   (recev_req),
    .recev_ack   (recev_ack),
    .pixel_a_out (a_out),
    .pixel_b_out (b_out),
    .pixel_c_out (c_out),
    .address     (address),
    .frame_done  (frame_done)
`ifdef PIXEL_FEEDER_CHECKSUM_EN
    ,
    .sum_r       (sum_r),
    .sum_g       (sum_g),
    .sum_b       (sum_b)
`endif
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [23:0] px, input logic req);
    in_valid  = v;
    {a_in, b_in, c_in} = px;
    recev_req = req;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(1'b0, 24'h0, 1'b0);
    step;
    step;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pix_out();
    return {8'h0, a_out, b_out, c_out};
  endfunction

  typedef struct {
    logic        v;
    logic [23:0] px;
    logic        req;
    logic        eack;
    logic        erdy;
    logic [13:0] eaddr;
    logic [23:0] epx;
  } vec_t;

  vec_t vt[19];

  initial begin
    // handshake of (10,20,30), then fill the FIFO, refuse a 5th pixel, drain it
    vt[0]  = '{1'b1, 24'h0A141E, 1'b0, 1'b0, 1'b1, 14'd0, 24'h000000};
    vt[1]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 1'b1, 14'd0, 24'h0A141E};
    vt[2]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 1'b1, 14'd0, 24'h0A141E};
    vt[3]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 14'd1, 24'h0A141E};
    vt[4]  = '{1'b1, 24'h111111, 1'b0, 1'b0, 1'b1, 14'd1, 24'h0A141E};
    vt[5]  = '{1'b1, 24'h222222, 1'b0, 1'b0, 1'b1, 14'd1, 24'h0A141E};
    vt[6]  = '{1'b1, 24'h333333, 1'b0, 1'b0, 1'b1, 14'd1, 24'h0A141E};
    vt[7]  = '{1'b1, 24'h444444, 1'b0, 1'b0, 1'b0, 14'd1, 24'h0A141E};
    vt[8]  = '{1'b1, 24'h555555, 1'b0, 1'b0, 1'b0, 14'd1, 24'h0A141E};
    vt[9]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 14'd1, 24'h111111};
    vt[10] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 14'd2, 24'h111111};
    vt[11] = '{1'b0, 24'h000000, 1'b1, 1'b1, 1'b1, 14'd2, 24'h222222};
    vt[12] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 14'd3, 24'h222222};
    vt[13] = '{1'b0, 24'h000000, 1'b1, 1'b1, 1'b1, 14'd3, 24'h333333};
    vt[14] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 14'd4, 24'h333333};
    vt[15] = '{1'b0, 24'h000000, 1'b1, 1'b1, 1'b1, 14'd4, 24'h444444};
    vt[16] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 14'd5, 24'h444444};
    vt[17] = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 14'd5, 24'h444444};
    vt[18] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 14'd5, 24'h444444};

    reset = 1'b1;
    drive(1'b0, 24'h0, 1'b0);
    @(negedge clk);
    do_reset;
    check("rst_ack",   32'(recev_ack),  32'd0);
    check("rst_done",  32'(frame_done), 32'd0);
    check("rst_addr",  32'(address),    32'd0);
    check("rst_pix",   pix_out(),       32'd0);
    check("rst_ready", 32'(in_ready),   32'd1);

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].v, vt[i].px, vt[i].req);
      step;
      check($sformatf("vec%0d_ack", i),   32'(recev_ack), 32'(vt[i].eack));
      check($sformatf("vec%0d_ready", i), 32'(in_ready),  32'(vt[i].erdy));
      check($sformatf("vec%0d_addr", i),  32'(address),   32'(vt[i].eaddr));
      check($sformatf("vec%0d_pix", i),   pix_out(),      32'(vt[i].epx));
    end

    // request held with an empty FIFO
    drive(1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step;
      check("empty_wait_ack", 32'(recev_ack), 32'd0);
    end
    drive(1'b1, 24'hABCDEF, 1'b1);
    step;
    check("push_vis_ack", 32'(recev_ack), 32'd0);
    drive(1'b0, 24'h0, 1'b1);
    step;
    check("late_ack", 32'(recev_ack), 32'd1);
    check("late_pix", pix_out(),      32'h00ABCDEF);
    drive(1'b0, 24'h0, 1'b0);
    step;
    check("late_addr", 32'(address), 32'd6);

    // reset in the middle of a handshake discards FIFO contents
    drive(1'b1, 24'h123456, 1'b0);
    step;
    drive(1'b1, 24'h777777, 1'b1);
    step;
    check("mid_ack_up", 32'(recev_ack), 32'd1);
    reset = 1'b1;
    drive(1'b0, 24'h0, 1'b1);
    step;
    reset = 1'b0;
    check("mid_rst_ack",   32'(recev_ack), 32'd0);
    check("mid_rst_addr",  32'(address),   32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    for (int i = 0; i < 5; i++) begin
      step;
      check("mid_rst_noack", 32'(recev_ack), 32'd0);
    end
    drive(1'b1, 24'h0F0F0F, 1'b1);
    step;
    drive(1'b0, 24'h0, 1'b1);
    step;
    check("mid_new_ack", 32'(recev_ack), 32'd1);
    check("mid_new_pix", pix_out(),      32'h000F0F0F);
    drive(1'b0, 24'h0, 1'b0);
    step;
    check("mid_new_addr", 32'(address), 32'd1);

    // full frame with a constant pixel, fastest legal handshake
    begin
      int   done  = 0;
      int   fdc   = 0;
      int   fd_at = -1;
      logic prev_ack = 1'b0;
      do_reset;
      for (int cyc = 0; cyc < 40000 && done < IMG; cyc++) begin
        drive(1'b1, 24'h0102FF, !recev_ack);
        step;
        if (prev_ack && !recev_ack) begin
          done++;
          if (done == 100) check("frame_addr100", 32'(address), 32'd100);
        end
        if (frame_done) begin
          fdc++;
          fd_at = done;
        end
        prev_ack = recev_ack;
      end
      check("frame_count", 32'(done), 32'(IMG));
      drive(1'b0, 24'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
        step;
        if (frame_done) fdc++;
      end
      check("frame_pulses", 32'(fdc),     32'd1);
      check("frame_at",     32'(fd_at),   32'(IMG));
      check("frame_addr",   32'(address), 32'd0);
`ifdef PIXEL_FEEDER_CHECKSUM_EN
      check("sum_r", 32'(sum_r), 32'd16384);
      check("sum_g", 32'(sum_g), 32'd32768);
      check("sum_b", 32'(sum_b), 32'd4177920);
`endif
    end

    // random traffic against a queue-level model
    begin
      logic [23:0] q[$];
      logic        ack_m = 1'b0;
      logic        fd_m;
      logic [23:0] pix_m = 24'h0;
      int          addr_m = 0;
      logic        v, req, pushed;
      logic [23:0] px;
      do_reset;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        v   = ($urandom_range(0, 3) != 0);
        req = ($urandom_range(0, 9) < 6);
        px  = 24'($urandom);
        check("rnd_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        pushed = v && (q.size() < DEPTH);
        fd_m   = 1'b0;
        if (!ack_m) begin
          if (req && q.size() > 0) begin
            ack_m = 1'b1;
            pix_m = q[0];
          end
        end else if (!req) begin
          void'(q.pop_front());
          ack_m  = 1'b0;
          fd_m   = (addr_m == IMG - 1);
          addr_m = (addr_m + 1) % IMG;
        end
        if (pushed) q.push_back(px);
        drive(v, px, req);
        step;
        check("rnd_ack",  32'(recev_ack),  32'(ack_m));
        check("rnd_pix",  pix_out(),       32'(pix_m));
        check("rnd_addr", 32'(address),    32'(addr_m));
        check("rnd_done", 32'(frame_done), 32'(fd_m));
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
